// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: shares one Wishbone-classic memory port between the core's
// instruction bus and data bus. One master is granted at a time (registered
// grant), the response is routed back to the owner, and a watchdog ends
// transfers the slave never acknowledges by returning FILL.
module wb_mem_arbiter #(
   parameter string       PRIO    = "RR",
   parameter int          TIMEOUT = 256,
   parameter logic [31:0] FILL    = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ibus_cyc,
   input  logic [31:0] ibus_adr,
   output logic [31:0] ibus_rdt,
   output logic        ibus_ack,
   input  logic        dbus_cyc,
   input  logic        dbus_we,
   input  logic [3:0]  dbus_sel,
   input  logic [31:0] dbus_adr,
   input  logic [31:0] dbus_dat,
   output logic [31:0] dbus_rdt,
   output logic        dbus_ack,
   output logic        mem_cyc,
   output logic        mem_we,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_dat,
   input  logic [31:0] mem_rdt,
   input  logic        mem_ack,
   output logic        timeout_o
);

   localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit            FIX_D   = (PRIO == "DBUS");
   localparam bit            FIX_I   = (PRIO == "IBUS");

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t        state, state_next;
   logic          last_owner, last_owner_next;   // 1 = dbus owned last
   logic [CW-1:0] count, count_next;
   logic          timeout_q, timeout_next;
   logic          owner_cyc;
   logic          timeout_hit;
   logic          owner_ack;
   logic [31:0]   owner_rdt;

   // Route the owner's request onto the shared bus; everything is zero in IDLE or reset
   always_comb begin
      owner_cyc = 1'b0;
      mem_cyc   = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 4'h0;
      mem_adr   = 32'h0;
      mem_dat   = 32'h0;
      if (!reset) begin
         case (state)
            GNT_I: begin
               owner_cyc = ibus_cyc;
               mem_cyc   = ibus_cyc;
               mem_sel   = 4'hF;
               mem_adr   = ibus_adr;
            end
            GNT_D: begin
               owner_cyc = dbus_cyc;
               mem_cyc   = dbus_cyc;
               mem_we    = dbus_we;
               mem_sel   = dbus_sel;
               mem_adr   = dbus_adr;
               mem_dat   = dbus_dat;
            end
            default: ;
         endcase
      end
   end

   // A real ack always beats the watchdog; the watchdog fires on the last allowed cycle
   assign timeout_hit = (TIMEOUT != 0) && owner_cyc && !mem_ack && (count == CNT_MAX);
   assign owner_ack   = (owner_cyc & mem_ack) | timeout_hit;
   assign owner_rdt   = timeout_hit ? FILL : mem_rdt;
   assign ibus_ack    = owner_ack & (state == GNT_I);
   assign dbus_ack    = owner_ack & (state == GNT_D);
   assign ibus_rdt    = ibus_ack ? owner_rdt : 32'h0;
   assign dbus_rdt    = dbus_ack ? owner_rdt : 32'h0;
   assign timeout_o   = timeout_q & ~reset;

   // Arbitration and transfer termination: decide the next grant, round-robin memory and watchdog count
   always_comb begin
      state_next      = state;
      last_owner_next = last_owner;
      count_next      = count;
      timeout_next    = timeout_q;
      case (state)
         IDLE: begin
            count_next = '0;
            if (ibus_cyc && dbus_cyc) begin
               if (FIX_D)           state_next = GNT_D;
               else if (FIX_I)      state_next = GNT_I;
               else if (last_owner) state_next = GNT_I;
               else                 state_next = GNT_D;
            end else if (ibus_cyc) begin
               state_next = GNT_I;
            end else if (dbus_cyc) begin
               state_next = GNT_D;
            end
         end
         GNT_I, GNT_D: begin
            if (!owner_cyc || mem_ack || timeout_hit) begin
               state_next      = IDLE;
               last_owner_next = (state == GNT_D);
               if (timeout_hit) timeout_next = 1'b1;
            end else begin
               count_next = count + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register; synchronous reset leaves ibus as the winner of the first round-robin tie
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         count      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_next;
         last_owner <= last_owner_next;
         count      <= count_next;
         timeout_q  <= timeout_next;
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed bench for the ibus/dbus memory arbiter. Two
// instances share the master/slave inputs: a round-robin one with a short
// watchdog and a fixed dbus-priority one; each is held in reset while the
// other is exercised. Expected acks go into per-instance queues that a
// negedge monitor drains.
module tb_wb_mem_arbiter;

   typedef struct packed {
      logic        who;    // 1 = dbus
      logic [31:0] rdt;
   } exp_t;

   logic        clock;
   logic        reset_r, reset_d;
   logic        ibus_cyc, dbus_cyc, dbus_we, mem_ack;
   logic [31:0] ibus_adr, dbus_adr, dbus_dat, mem_rdt;
   logic [3:0]  dbus_sel;

   logic [31:0] r_ibus_rdt, r_dbus_rdt, r_mem_adr, r_mem_dat;
   logic        r_ibus_ack, r_dbus_ack, r_mem_cyc, r_mem_we, r_timeout_o;
   logic [3:0]  r_mem_sel;
   logic [31:0] d_ibus_rdt, d_dbus_rdt, d_mem_adr, d_mem_dat;
   logic        d_ibus_ack, d_dbus_ack, d_mem_cyc, d_mem_we, d_timeout_o;
   logic [3:0]  d_mem_sel;

   exp_t q_r[$];
   exp_t q_d[$];
   int   total = 0;
   int   bad   = 0;

   wb_mem_arbiter #(.PRIO("RR"), .TIMEOUT(4), .FILL(32'h0000_0013)) dut_rr (
      .clock(clock), .reset(reset_r),
      .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(r_ibus_rdt), .ibus_ack(r_ibus_ack),
      .dbus_cyc(dbus_cyc), .dbus_we(dbus_we), .dbus_sel(dbus_sel), .dbus_adr(dbus_adr),
      .dbus_dat(dbus_dat), .dbus_rdt(r_dbus_rdt), .dbus_ack(r_dbus_ack),
      .mem_cyc(r_mem_cyc), .mem_we(r_mem_we), .mem_sel(r_mem_sel), .mem_adr(r_mem_adr),
      .mem_dat(r_mem_dat), .mem_rdt(mem_rdt), .mem_ack(mem_ack), .timeout_o(r_timeout_o)
   );

   wb_mem_arbiter #(.PRIO("DBUS"), .TIMEOUT(256), .FILL(32'h0000_0013)) dut_db (
      .clock(clock), .reset(reset_d),
      .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(d_ibus_rdt), .ibus_ack(d_ibus_ack),
      .dbus_cyc(dbus_cyc), .dbus_we(dbus_we), .dbus_sel(dbus_sel), .dbus_adr(dbus_adr),
      .dbus_dat(dbus_dat), .dbus_rdt(d_dbus_rdt), .dbus_ack(d_dbus_ack),
      .mem_cyc(d_mem_cyc), .mem_we(d_mem_we), .mem_sel(d_mem_sel), .mem_adr(d_mem_adr),
      .mem_dat(d_mem_dat), .mem_rdt(mem_rdt), .mem_ack(mem_ack), .timeout_o(d_timeout_o)
   );

   // Free-running clock, 10 time units per period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Wait for the active edge, drive one cycle of inputs, then let them settle before any check
   task automatic applyStimulus(input logic ic, input logic [31:0] ia,
                                input logic dc, input logic dwe, input logic [3:0] ds,
                                input logic [31:0] da, input logic [31:0] dd,
                                input logic ack, input logic [31:0] rdt);
      @(posedge clock);
      #1;
      ibus_cyc = ic;  ibus_adr = ia;
      dbus_cyc = dc;  dbus_we  = dwe; dbus_sel = ds; dbus_adr = da; dbus_dat = dd;
      mem_ack  = ack; mem_rdt  = rdt;
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   // Two reset cycles on the round-robin instance with live requests and a stray slave ack
   task automatic doReset();
      reset_r = 1'b1;
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 32'h5555_5555);
      checkOutput("reset_mem_cyc", r_mem_cyc, 0);
      checkOutput("reset_ibus_ack", r_ibus_ack, 0);
      checkOutput("reset_dbus_ack", r_dbus_ack, 0);
      checkOutput("reset_mem_adr", r_mem_adr, 0);
      checkOutput("reset_timeout", r_timeout_o, 0);
      idleCycle();
      reset_r = 1'b0;
   endtask

   // Scoreboard monitor: every master ack must match the oldest expected response of its instance
   always @(negedge clock) begin
      exp_t e;
      total++;
      if (r_ibus_ack === 1'b1 && r_dbus_ack === 1'b1) begin
         bad++;
         $display("[TB] FAIL rr_dual_ack: got both acks want at most one");
      end
      if (r_ibus_ack === 1'b1 || r_dbus_ack === 1'b1) begin
         total++;
         if (q_r.size() == 0) begin
            bad++;
            $display("[TB] FAIL rr_unexpected_ack: got ack dbus=%0d rdt %h want none", r_dbus_ack,
                     r_dbus_ack ? r_dbus_rdt : r_ibus_rdt);
         end else begin
            e = q_r.pop_front();
            if (e.who !== r_dbus_ack || e.rdt !== (r_dbus_ack ? r_dbus_rdt : r_ibus_rdt)) begin
               bad++;
               $display("[TB] FAIL rr_ack: got dbus=%0d rdt %h want dbus=%0d rdt %h", r_dbus_ack,
                        r_dbus_ack ? r_dbus_rdt : r_ibus_rdt, e.who, e.rdt);
            end
         end
      end
      if (d_ibus_ack === 1'b1 || d_dbus_ack === 1'b1) begin
         total++;
         if (q_d.size() == 0) begin
            bad++;
            $display("[TB] FAIL db_unexpected_ack: got ack dbus=%0d want none", d_dbus_ack);
         end else begin
            e = q_d.pop_front();
            if (e.who !== d_dbus_ack || e.rdt !== (d_dbus_ack ? d_dbus_rdt : d_ibus_rdt)) begin
               bad++;
               $display("[TB] FAIL db_ack: got dbus=%0d rdt %h want dbus=%0d rdt %h", d_dbus_ack,
                        d_dbus_ack ? d_dbus_rdt : d_ibus_rdt, e.who, e.rdt);
            end
         end
      end
   end

   // Directed scenarios
   initial begin
      reset_r  = 1'b1; reset_d = 1'b1;
      ibus_cyc = 1'b0; ibus_adr = 32'h0;
      dbus_cyc = 1'b0; dbus_we = 1'b0; dbus_sel = 4'h0; dbus_adr = 32'h0; dbus_dat = 32'h0;
      mem_ack  = 1'b0; mem_rdt = 32'h0;

      // Single fetch: one cycle of arbitration latency, ack in the second grant cycle
      doReset();
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("fetch_latency_cyc", r_mem_cyc, 0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("fetch_mem_cyc", r_mem_cyc, 1);
      checkOutput("fetch_mem_sel", r_mem_sel, 4'hF);
      checkOutput("fetch_mem_we", r_mem_we, 0);
      checkOutput("fetch_mem_adr", r_mem_adr, 32'h100);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      q_r.push_back('{who: 1'b0, rdt: 32'hDEAD_BEEF});
      idleCycle();
      checkOutput("fetch_done_cyc", r_mem_cyc, 0);

      // Round-robin with both masters requesting and mem_ack stuck high: I,D,I,D with idle gaps
      doReset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 32'h1000 + k);
         checkOutput("rr_gap_cyc", r_mem_cyc, 0);
         applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 32'h1000 + k);
         checkOutput("rr_grant_adr", r_mem_adr, (k % 2 == 0) ? 32'h200 : 32'h300);
         q_r.push_back('{who: (k % 2 == 1), rdt: 32'h1000 + k});
      end
      idleCycle();
      checkOutput("rr_end_cyc", r_mem_cyc, 0);

      // Fixed dbus priority: the write completes first, then the pending fetch
      reset_r = 1'b1;
      reset_d = 1'b0;
      applyStimulus(1'b1, 32'h400, 1'b1, 1'b1, 4'h3, 32'h500, 32'h1234, 1'b0, 32'h0);
      checkOutput("db_latency_cyc", d_mem_cyc, 0);
      applyStimulus(1'b1, 32'h400, 1'b1, 1'b1, 4'h3, 32'h500, 32'h1234, 1'b1, 32'h55);
      checkOutput("db_mem_cyc", d_mem_cyc, 1);
      checkOutput("db_mem_dat", d_mem_dat, 32'h1234);
      checkOutput("db_mem_we", d_mem_we, 1);
      checkOutput("db_mem_sel", d_mem_sel, 4'h3);
      checkOutput("db_mem_adr", d_mem_adr, 32'h500);
      q_d.push_back('{who: 1'b1, rdt: 32'h55});
      applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("db_gap_cyc", d_mem_cyc, 0);
      applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h66);
      checkOutput("db_fetch_adr", d_mem_adr, 32'h400);
      checkOutput("db_fetch_sel", d_mem_sel, 4'hF);
      q_d.push_back('{who: 1'b0, rdt: 32'h66});
      idleCycle();
      reset_d = 1'b1;

      // Watchdog: slave never acks, the fourth grant cycle returns FILL and sets the sticky flag
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0, 32'h0);
         checkOutput("wd_mem_cyc", r_mem_cyc, 1);
         checkOutput("wd_flag_early", r_timeout_o, 0);
         if (i == 4) q_r.push_back('{who: 1'b1, rdt: 32'h0000_0013});
      end
      idleCycle();
      checkOutput("wd_abort_cyc", r_mem_cyc, 0);
      checkOutput("wd_flag_set", r_timeout_o, 1);
      idleCycle();
      checkOutput("wd_flag_sticky", r_timeout_o, 1);

      // Ack exactly at the last watchdog cycle: real data wins, flag stays clear
      doReset();
      applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("late_flag_cleared", r_timeout_o, 0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, (i == 4), 32'hCAFE_F00D);
         if (i == 4) q_r.push_back('{who: 1'b0, rdt: 32'hCAFE_F00D});
      end
      idleCycle();
      checkOutput("late_flag_clear", r_timeout_o, 0);

      // Reset raised in the middle of a dbus grant: bus drops at once, no acks, ibus wins the next tie
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0, 1'b0, 32'h0);
      checkOutput("rst_pre_cyc", r_mem_cyc, 1);
      reset_r = 1'b1;
      mem_ack = 1'b1;
      mem_rdt = 32'h99;
      #1;
      checkOutput("rst_mid_cyc", r_mem_cyc, 0);
      checkOutput("rst_mid_dack", r_dbus_ack, 0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0, 1'b1, 32'h99);
      checkOutput("rst_hold_cyc", r_mem_cyc, 0);
      idleCycle();
      checkOutput("rst_drop_cyc", r_mem_cyc, 0);
      reset_r = 1'b0;
      applyStimulus(1'b1, 32'h900, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0, 1'b0, 32'h0);
      checkOutput("rst_after_idle", r_mem_cyc, 0);
      applyStimulus(1'b1, 32'h900, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0, 1'b1, 32'h77);
      checkOutput("rst_after_adr", r_mem_adr, 32'h900);
      q_r.push_back('{who: 1'b0, rdt: 32'h77});
      idleCycle();

      // Abort: dbus drops cyc before any ack; no ack, and dbus becomes last owner for the next tie
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'hA00, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'hA00, 32'h0, 1'b0, 32'h0);
      checkOutput("abort_pre_cyc", r_mem_cyc, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hBAD);
      checkOutput("abort_cyc", r_mem_cyc, 0);
      applyStimulus(1'b1, 32'hB00, 1'b1, 1'b0, 4'hF, 32'hA00, 32'h0, 1'b0, 32'h0);
      checkOutput("abort_gap_cyc", r_mem_cyc, 0);
      applyStimulus(1'b1, 32'hB00, 1'b1, 1'b0, 4'hF, 32'hA00, 32'h0, 1'b1, 32'h88);
      checkOutput("abort_next_adr", r_mem_adr, 32'hB00);
      q_r.push_back('{who: 1'b0, rdt: 32'h88});
      idleCycle();
      idleCycle();
      idleCycle();

      // Any expected response still queued was never delivered
      checkOutput("rr_queue_empty", q_r.size(), 0);
      checkOutput("db_queue_empty", q_d.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
